// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared definitions for the data-side bus responder.
//   - Region codes decoded from addr[31:28].
//   - Peripheral register offsets decoded from addr[7:0].
//   - CTRL register bit positions.
//   - merge_lanes(): byte-lane merge used by every byte-writable register.
package data_bus_pkg;

    // Region codes (addr[31:28])
    localparam logic [3:0] RamRegion = 4'h0;
    localparam logic [3:0] PerRegion = 4'h1;

    // Peripheral register offsets (addr[7:0])
    localparam logic [7:0] TimerCountAddr   = 8'h00;
    localparam logic [7:0] TimerCompareAddr = 8'h04;
    localparam logic [7:0] TimerCtrlAddr    = 8'h08;
    localparam logic [7:0] GpioOutAddr      = 8'h0C;
    localparam logic [7:0] GpioInAddr       = 8'h10;

    // CTRL bit positions
    localparam int CtrlEnBit         = 0;
    localparam int CtrlFlagBit       = 1;
    localparam int CtrlAutoreloadBit = 2;
    localparam int CtrlIeBit         = 3;

    // Replace the bytes of old_word whose lane enable is set with the
    // corresponding bytes of new_word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_bus_timer.sv
// data_bus_timer: free-running 32-bit timer with compare match, optional
// auto-reload and a level interrupt.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   count_we     store to COUNT this cycle
//   compare_we   store to COMPARE this cycle
//   ctrl_we      store to CTRL this cycle (only lane 0 carries control bits)
//   sel          byte-lane enables of the store
//   wdata        store data
//   count        COUNT register
//   compare      COMPARE register
//   ctrl         CTRL register as read by software (EN, FLAG, AUTORELOAD, IE)
//   timer_int    registered interrupt request (FLAG & IE)
module data_bus_timer
    import data_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic        ctrl_we,
    input  logic [3:0]  sel,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic [31:0] ctrl,
    output logic        timer_int
);

    logic        en_q;
    logic        flag_q;
    logic        autoreload_q;
    logic        ie_q;

    logic        match;
    logic        ctrl_lane_we;
    logic [31:0] count_next;
    logic [31:0] compare_next;
    logic        en_next;
    logic        flag_next;
    logic        autoreload_next;
    logic        ie_next;

    // Match is judged on the register values held during this cycle.
    assign match        = en_q && (count == compare);
    assign ctrl_lane_we = ctrl_we && sel[0];

    always_comb begin
        count_next      = count;
        compare_next    = compare;
        en_next         = en_q;
        flag_next       = flag_q;
        autoreload_next = autoreload_q;
        ie_next         = ie_q;

        // A software store to COUNT overrides both increment and reload.
        if (count_we && (sel != 4'b0000)) begin
            count_next = merge_lanes(count, wdata, sel);
        end else if (en_q) begin
            if (match && autoreload_q) begin
                count_next = 32'h0;
            end else begin
                count_next = count + 32'd1;
            end
        end

        if (compare_we) begin
            compare_next = merge_lanes(compare, wdata, sel);
        end

        if (ctrl_lane_we) begin
            en_next         = wdata[CtrlEnBit];
            autoreload_next = wdata[CtrlAutoreloadBit];
            ie_next         = wdata[CtrlIeBit];
        end

        // Setting on a match beats a simultaneous write-1-to-clear.
        if (match) begin
            flag_next = 1'b1;
        end else if (ctrl_lane_we && wdata[CtrlFlagBit]) begin
            flag_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= 32'h0;
            compare      <= 32'hFFFF_FFFF;
            en_q         <= 1'b0;
            flag_q       <= 1'b0;
            autoreload_q <= 1'b0;
            ie_q         <= 1'b0;
            timer_int    <= 1'b0;
        end else begin
            count        <= count_next;
            compare      <= compare_next;
            en_q         <= en_next;
            flag_q       <= flag_next;
            autoreload_q <= autoreload_next;
            ie_q         <= ie_next;
            timer_int    <= flag_next & ie_next;
        end
    end

    always_comb begin
        ctrl                    = 32'h0;
        ctrl[CtrlEnBit]         = en_q;
        ctrl[CtrlFlagBit]       = flag_q;
        ctrl[CtrlAutoreloadBit] = autoreload_q;
        ctrl[CtrlIeBit]         = ie_q;
    end

endmodule

// File: rtl/data_bus.sv
// data_bus: data-side responder for the core's RAM port.
// Region 0 is a byte-writable word RAM, region 1 holds the timer and GPIO
// registers; all other regions read as zero and ignore stores.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   ce_i          access enable
//   we_i          1 = store, 0 = load
//   addr_i        byte address
//   sel_i         byte-lane enables for stores
//   data_i        store data
//   data_o        load data, combinational (same cycle as the request)
//   gpio_i        external inputs, read through GPIO_IN
//   gpio_o        GPIO output register
//   timer_int_o   timer interrupt request (level)
module data_bus
    import data_bus_pkg::*;
#(
    parameter int DataMemNum     = 131072,
    parameter int DataMemNumLog2 = 17,
    parameter int GpioWidth      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce_i,
    input  logic                 we_i,
    input  logic [31:0]          addr_i,
    input  logic [3:0]           sel_i,
    input  logic [31:0]          data_i,
    output logic [31:0]          data_o,
    input  logic [GpioWidth-1:0] gpio_i,
    output logic [GpioWidth-1:0] gpio_o,
    output logic                 timer_int_o
);

    logic [31:0] mem [DataMemNum];

    logic [3:0]                region;
    logic                      ram_sel;
    logic                      per_sel;
    logic [7:0]                offset;
    logic [DataMemNumLog2-1:0] word_idx;
    logic                      wr;
    logic                      rd;

    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] ctrl;
    logic [31:0] gpio_merged;

    assign region   = addr_i[31:28];
    assign ram_sel  = (region == RamRegion);
    assign per_sel  = (region == PerRegion);
    assign offset   = addr_i[7:0];
    assign word_idx = addr_i[DataMemNumLog2+1:2];
    assign wr       = ce_i && we_i;
    assign rd       = ce_i && !we_i && !rst;

    // Address bits between the RAM index and the region code alias, the low
    // two bits are ignored, and the GPIO register keeps only its own width.
    logic unused_bits;
    assign unused_bits = ^{addr_i[27:DataMemNumLog2+2], addr_i[1:0],
                           gpio_merged[31:GpioWidth]};

    // RAM store, one byte lane at a time. Contents are never reset.
    always_ff @(posedge clk) begin
        if (wr && ram_sel) begin
            for (int k = 0; k < 4; k++) begin
                if (sel_i[k]) begin
                    mem[word_idx][8*k +: 8] <= data_i[8*k +: 8];
                end
            end
        end
    end

    data_bus_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr && per_sel && (offset == TimerCountAddr)),
        .compare_we (wr && per_sel && (offset == TimerCompareAddr)),
        .ctrl_we    (wr && per_sel && (offset == TimerCtrlAddr)),
        .sel        (sel_i),
        .wdata      (data_i),
        .count      (count),
        .compare    (compare),
        .ctrl       (ctrl),
        .timer_int  (timer_int_o)
    );

    assign gpio_merged = merge_lanes(32'(gpio_o), data_i, sel_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_o <= '0;
        end else if (wr && per_sel && (offset == GpioOutAddr)) begin
            gpio_o <= gpio_merged[GpioWidth-1:0];
        end
    end

    // Load path: zero unless a load is presented; sel_i does not mask.
    always_comb begin
        data_o = 32'h0;
        if (rd) begin
            if (ram_sel) begin
                data_o = mem[word_idx];
            end else if (per_sel) begin
                case (offset)
                    TimerCountAddr:   data_o = count;
                    TimerCompareAddr: data_o = compare;
                    TimerCtrlAddr:    data_o = ctrl;
                    GpioOutAddr:      data_o = 32'(gpio_o);
                    GpioInAddr:       data_o = 32'(gpio_i);
                    default:          data_o = 32'h0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_bus.sv
// tb_data_bus: directed scenarios followed by randomized traffic, all
// checked against a behavioural model of the bus map kept in this file.
module tb_data_bus;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [3:0]  sel_i = 4'h0;
    logic [31:0] data_i = 32'h0;
    logic [31:0] data_o;
    logic [15:0] gpio_i = 16'h0;
    logic [15:0] gpio_o;
    logic        timer_int_o;

    always #5 clk = ~clk;

    data_bus dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .sel_i       (sel_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .gpio_i      (gpio_i),
        .gpio_o      (gpio_o),
        .timer_int_o (timer_int_o)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Memory map as software sees it: a sparse word store plus named
    // registers, advanced once per clock edge.
    logic [31:0] m_mem [int unsigned];
    logic [31:0] m_count, m_cmp;
    logic        m_en, m_flag, m_ar, m_ie, m_int;
    logic [15:0] m_gpio;

    function automatic logic [31:0] lanes(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
        int unsigned idx;
        v = 32'h0;
        if (a[31:28] == 4'h0) begin
            idx = int'(a[18:2]);
            if (!m_mem.exists(idx)) return 1'b0;
            v = m_mem[idx];
        end else if (a[31:28] == 4'h1) begin
            case (a[7:0])
                8'h00: v = m_count;
                8'h04: v = m_cmp;
                8'h08: v = {28'h0, m_ie, m_ar, m_flag, m_en};
                8'h0C: v = {16'h0, m_gpio};
                8'h10: v = {16'h0, gpio_i};
                default: v = 32'h0;
            endcase
        end
        return 1'b1;
    endfunction

    task automatic model_step(input logic r, input logic c, input logic w,
                              input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d);
        int unsigned idx;
        bit hit, per, clr;
        idx = int'(a[18:2]);
        if (r) begin
            // A store during reset may or may not land in RAM: forget the word.
            if (c && w && a[31:28] == 4'h0 && s != 4'h0) m_mem.delete(idx);
            m_count = 32'h0; m_cmp = 32'hFFFF_FFFF;
            m_en = 0; m_flag = 0; m_ar = 0; m_ie = 0; m_int = 0; m_gpio = 16'h0;
            return;
        end
        per = c && w && (a[31:28] == 4'h1);
        if (c && w && a[31:28] == 4'h0 && s != 4'h0) begin
            if (m_mem.exists(idx)) m_mem[idx] = lanes(m_mem[idx], d, s);
            else if (s == 4'hF) m_mem[idx] = d;
        end
        hit = m_en && (m_count == m_cmp);
        clr = 0;
        if (per && a[7:0] == 8'h00 && s != 4'h0) m_count = lanes(m_count, d, s);
        else if (m_en) m_count = (hit && m_ar) ? 32'h0 : m_count + 1;
        if (per && a[7:0] == 8'h04) m_cmp = lanes(m_cmp, d, s);
        if (per && a[7:0] == 8'h08 && s[0]) begin
            m_en = d[0]; m_ar = d[2]; m_ie = d[3]; clr = d[1];
        end
        if (hit) m_flag = 1;
        else if (clr) m_flag = 0;
        if (per && a[7:0] == 8'h0C) m_gpio = 16'(lanes({16'h0, m_gpio}, d, s));
        m_int = m_flag & m_ie;
    endtask

    // ---------------- driver ----------------
    // Drive at the falling edge, check the combinational load data before
    // the rising edge, then check registered outputs just after it.
    task automatic do_cycle(input logic r, input logic c, input logic w,
                            input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d);
        logic [31:0] v;
        bit known;
        @(negedge clk);
        rst = r; ce_i = c; we_i = w; addr_i = a; sel_i = s; data_i = d;
        #1;
        last_rd = data_o;
        if (r || !c || w) begin
            known = 1'b1; v = 32'h0;
        end else begin
            known = model_read(a, v);
        end
        if (known) begin
            exp_q.push_back(v);
            check_val($sformatf("data_o@%08h", a), data_o, exp_q.pop_front());
        end
        @(posedge clk);
        model_step(r, c, w, a, s, d);
        #1;
        check_val("gpio_o", {16'h0, gpio_o}, {16'h0, m_gpio});
        check_val("timer_int_o", {31'h0, timer_int_o}, {31'h0, m_int});
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        do_cycle(1'b0, 1'b1, 1'b1, a, s, d);
    endtask

    task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        do_cycle(1'b0, 1'b1, 1'b0, a, 4'hF, $urandom);
        check_val(tag, last_rd, exp);
    endtask

    task automatic do_reset();
        do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    localparam logic [31:0] A_CNT  = 32'h1000_0000;
    localparam logic [31:0] A_CMP  = 32'h1000_0004;
    localparam logic [31:0] A_CTRL = 32'h1000_0008;
    localparam logic [31:0] A_GOUT = 32'h1000_000C;
    localparam logic [31:0] A_GIN  = 32'h1000_0010;

    int unsigned pool [8] = '{0, 1, 2, 3, 32'h40, 32'h41, 32'h1FFFE, 32'h1FFFF};

    function automatic logic [31:0] ram_addr();
        return (32'(pool[$urandom_range(0, 7)]) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        int op;

        do_reset();
        do_reset();
        check_val("rst_int", {31'h0, timer_int_o}, 32'h0);
        bus_rd("rst_count", A_CNT, 32'h0);
        bus_rd("rst_compare", A_CMP, 32'hFFFF_FFFF);
        bus_rd("rst_ctrl", A_CTRL, 32'h0);

        // RAM byte lanes
        bus_wr(32'h100, 32'h1122_3344, 4'b1111);
        bus_wr(32'h100, 32'h00AA_0000, 4'b0100);
        bus_rd("ram_lane", 32'h100, 32'h11AA_3344);

        // Unmapped region and ce low
        bus_wr(32'h0, 32'hCAFE_F00D, 4'b1111);
        bus_rd("unmapped_rd", 32'h2000_0000, 32'h0);
        bus_wr(32'h2000_0000, 32'hDEAD_BEEF, 4'b1111);
        bus_rd("ram0_kept", 32'h0, 32'hCAFE_F00D);
        do_cycle(1'b0, 1'b0, 1'b0, 32'h100, 4'hF, 32'h0);
        check_val("ce_low", last_rd, 32'h0);

        // Timer with auto-reload
        do_reset();
        bus_wr(A_CMP, 32'd5, 4'hF);
        bus_wr(A_CTRL, 32'hD, 4'hF);
        for (int i = 0; i <= 5; i++) bus_rd("cnt_run", A_CNT, 32'(i));
        check_val("int_after_match", {31'h0, timer_int_o}, 32'h1);
        bus_rd("cnt_reload", A_CNT, 32'h0);
        bus_rd("ctrl_flag", A_CTRL, 32'hF);

        // Flag clear collides with a match: set wins
        for (int i = 2; i <= 4; i++) bus_rd("cnt_run2", A_CNT, 32'(i));
        bus_wr(A_CTRL, 32'hF, 4'h1);
        bus_rd("flag_kept", A_CTRL, 32'hF);
        check_val("int_kept", {31'h0, timer_int_o}, 32'h1);
        bus_wr(A_CTRL, 32'hF, 4'h1);
        check_val("int_cleared", {31'h0, timer_int_o}, 32'h0);
        bus_rd("flag_clear", A_CTRL, 32'hD);

        // COUNT write priority and wrap
        bus_wr(A_CTRL, 32'h1, 4'h1);
        bus_wr(A_CNT, 32'hFFFF_FFFE, 4'hF);
        bus_rd("cnt_written", A_CNT, 32'hFFFF_FFFE);
        bus_rd("cnt_max", A_CNT, 32'hFFFF_FFFF);
        bus_rd("cnt_wrap", A_CNT, 32'h0);

        // GPIO and reset
        bus_wr(A_GOUT, 32'h0000_BEEF, 4'b0011);
        check_val("gpio_out", {16'h0, gpio_o}, 32'hBEEF);
        gpio_i = 16'h1234;
        bus_rd("gpio_in", A_GIN, 32'h0000_1234);
        bus_wr(A_CTRL, 32'h9, 4'h1);
        bus_wr(A_CNT, 32'd5, 4'hF);
        do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check_val("int_pre_rst", {31'h0, timer_int_o}, 32'h1);
        do_reset();
        check_val("rst_gpio", {16'h0, gpio_o}, 32'h0);
        check_val("rst_int2", {31'h0, timer_int_o}, 32'h0);
        bus_rd("rst_count2", A_CNT, 32'h0);
        bus_rd("rst_compare2", A_CMP, 32'hFFFF_FFFF);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            op = $urandom_range(0, 15);
            s  = 4'($urandom_range(0, 15));
            d  = $urandom;
            case (op)
                0, 1, 2: bus_wr(ram_addr(), d, s);
                3, 4, 5: do_cycle(1'b0, 1'b1, 1'b0, ram_addr(), s, d);
                6: begin
                    a = 32'h1000_0000 | (32'($urandom_range(0, 5)) << 2);
                    do_cycle(1'b0, 1'b1, 1'b0, a, s, d);
                end
                7: bus_wr(A_CNT, 32'($urandom_range(0, 40)), s);
                8: bus_wr(A_CMP, 32'($urandom_range(0, 40)), s);
                9: bus_wr(A_CTRL, 32'($urandom_range(0, 15)), s);
                10: bus_wr(A_GOUT, d, s);
                11: begin
                    a = {4'($urandom_range(2, 15)), 28'($urandom)};
                    do_cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), a, s, d);
                end
                12: do_cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), ram_addr(), s, d);
                13: begin
                    gpio_i = 16'($urandom);
                    do_cycle(1'b0, 1'b1, 1'b0, A_GIN, s, d);
                end
                14: begin
                    if ($urandom_range(0, 20) == 0)
                        do_cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                 ram_addr(), s, d);
                    else
                        do_cycle(1'b0, 1'b1, 1'b0, A_CTRL, s, d);
                end
                default: do_cycle(1'b0, 1'b1, 1'b0, A_CNT, s, d);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
